// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel type and index-width helper for the frame-buffer arbiter.
package vga_pkg;

  localparam int unsigned H_ACT     = 640;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_ACT     = 480;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned FB_PIXELS = H_ACT * V_ACT;

  typedef logic [DATA_W-1:0] pixel_t;

  // Index width that stays >= 1 even for a single client.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Client request bus and frame-buffer RAM port seen by the arbiter (slave) and its environment.
interface vga_fb_arbiter_if #(
  parameter int unsigned N_CLI  = 2,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 12
) ();

  logic [N_CLI-1:0]        cli_req;
  logic [N_CLI-1:0]        cli_we;
  logic [N_CLI*ADDR_W-1:0] cli_addr;
  logic [N_CLI*DATA_W-1:0] cli_wdata;
  logic [N_CLI-1:0]        cli_gnt;
  logic [N_CLI-1:0]        cli_rvalid;
  logic [DATA_W-1:0]       cli_rdata;

  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  cli_req, cli_we, cli_addr, cli_wdata, mem_rdata,
    output cli_gnt, cli_rvalid, cli_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cli_req, cli_we, cli_addr, cli_wdata, mem_rdata,
    input  cli_gnt, cli_rvalid, cli_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vga_rr_arbiter.sv
// Combinational N-way round-robin: first requester after ptr (wrapping) gets a one-hot grant.
module vga_rr_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned N_CLI = 2,
  localparam int unsigned PTR_W = idx_w(N_CLI)
) (
  input  logic             en,
  input  logic [N_CLI-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_CLI-1:0] gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= int'(N_CLI); k++) begin
      idx = (int'(ptr) + k) % int'(N_CLI);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port scheduler: scan-out prefetch owns video slots, clients share the rest round-robin.
// Build option FB_VBLANK_ONLY_EN restricts client slots to vertical blanking.
module vga_fb_arbiter #(
  parameter int unsigned H_ACT   = vga_pkg::H_ACT,
  parameter int unsigned H_TOTAL = vga_pkg::H_TOTAL,
  parameter int unsigned V_ACT   = vga_pkg::V_ACT,
  parameter int unsigned V_TOTAL = vga_pkg::V_TOTAL,
  parameter int unsigned ADDR_W  = vga_pkg::ADDR_W,
  parameter int unsigned DATA_W  = vga_pkg::DATA_W,
  parameter int unsigned N_CLI   = 2
) (
  input  logic              clk_25m,
  input  logic              rst,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  vga_fb_arbiter_if.slave   bus,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_active
);

  localparam int unsigned PTR_W = vga_pkg::idx_w(N_CLI);

  logic [9:0]        v_nxt;
  logic              vid_slot;
  logic              cli_slot;
  logic [N_CLI-1:0]  gnt;
  logic [PTR_W-1:0]  win_idx;

  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              vid_q;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_CLI-1:0]  rd_tag_q, rd_tag_d;

  assign v_nxt    = (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
  // Prefetch one pixel ahead: x+1 on this line, or pixel 0 of the next line at h=H_TOTAL-1.
  assign vid_slot = ((h_count <= 10'(H_ACT - 2)) && (v_count < 10'(V_ACT))) ||
                    ((h_count == 10'(H_TOTAL - 1)) && (v_nxt < 10'(V_ACT)));

`ifdef FB_VBLANK_ONLY_EN
  assign cli_slot = !vid_slot && (v_count >= 10'(V_ACT));
`else
  assign cli_slot = !vid_slot;
`endif

  vga_rr_arbiter #(
    .N_CLI (N_CLI)
  ) u_rr (
    .en  (cli_slot && !rst),
    .req (bus.cli_req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(N_CLI); i++) begin
      if (gnt[i]) win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = vid_addr_q;
    bus.mem_wdata = '0;
    if (!rst) begin
      if (vid_slot) begin
        bus.mem_en = 1'b1;
      end else if (|gnt) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cli_we[win_idx];
        bus.mem_addr  = bus.cli_addr[win_idx*ADDR_W +: ADDR_W];
        bus.mem_wdata = bus.cli_wdata[win_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.cli_gnt    = gnt;
  assign bus.cli_rvalid = rd_tag_q;
  assign bus.cli_rdata  = bus.mem_rdata;
  assign pix_active     = vid_q;
  assign pix_data       = vid_q ? bus.mem_rdata : '0;

  always_comb begin
    vid_addr_d = vid_addr_q;
    // Rewind one cycle before the frame-start fetch at (H_TOTAL-1, V_TOTAL-1).
    if ((h_count == 10'(H_TOTAL - 2)) && (v_count == 10'(V_TOTAL - 1))) begin
      vid_addr_d = '0;
    end else if (vid_slot) begin
      vid_addr_d = vid_addr_q + ADDR_W'(1);
    end
    rr_ptr_d = (|gnt) ? win_idx : rr_ptr_q;
    rd_tag_d = gnt & ~bus.cli_we;
  end

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      vid_addr_q <= ADDR_W'(1);
      vid_q      <= 1'b0;
      rr_ptr_q   <= PTR_W'(N_CLI - 1);
      rd_tag_q   <= '0;
    end else begin
      vid_addr_q <= vid_addr_d;
      vid_q      <= vid_slot;
      rr_ptr_q   <= rr_ptr_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 16x8 (24x12 total) raster with a behavioural RAM.
module tb_vga_fb_arbiter;

  localparam int unsigned H_ACT   = 16;
  localparam int unsigned H_TOTAL = 24;
  localparam int unsigned V_ACT   = 8;
  localparam int unsigned V_TOTAL = 12;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned N_CLI   = 2;
  localparam int unsigned FRAME   = H_TOTAL * V_TOTAL;

`ifdef FB_VBLANK_ONLY_EN
  localparam int S2_H = 0;
  localparam int S2_V = V_ACT;
  localparam int G4_H = 0;
  localparam int G4_V = V_ACT;
`else
  localparam int S2_H = H_ACT - 1;
  localparam int S2_V = 0;
  localparam int G4_H = H_ACT - 1;
  localparam int G4_V = 2;
`endif

  logic              clk_25m = 1'b0;
  logic              rst;
  logic [9:0]        h_count;
  logic [9:0]        v_count;
  logic [DATA_W-1:0] pix_data;
  logic              pix_active;
  logic [DATA_W-1:0] ram [0:255];
  bit                wrote = 1'b0;
  int                n_checks = 0;
  int                n_fail = 0;

  vga_fb_arbiter_if #(.N_CLI(N_CLI), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_arbiter #(
    .H_ACT   (H_ACT),
    .H_TOTAL (H_TOTAL),
    .V_ACT   (V_ACT),
    .V_TOTAL (V_TOTAL),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .N_CLI   (N_CLI)
  ) dut (
    .clk_25m    (clk_25m),
    .rst        (rst),
    .h_count    (h_count),
    .v_count    (v_count),
    .bus        (bus),
    .pix_data   (pix_data),
    .pix_active (pix_active)
  );

  always #20 clk_25m = ~clk_25m;

  // Synchronous single-port RAM, read data one clock after the access.
  always @(posedge clk_25m) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_25m);
    #1;
    if (h_count == 10'(H_TOTAL - 1)) begin
      h_count = '0;
      v_count = (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count = h_count + 10'd1;
    end
  endtask

  task automatic goto(input int h, input int v);
    while (!(int'(h_count) == h && int'(v_count) == v)) step();
  endtask

  function automatic logic [DATA_W-1:0] pix_exp(input int h, input int v);
    int a;
    a = v * int'(H_ACT) + h;
    if (a == 5 && wrote) return 12'hABC;
    return a[DATA_W-1:0];
  endfunction

  task automatic check_pix();
    bit act;
    act = (h_count < 10'(H_ACT)) && (v_count < 10'(V_ACT));
    check($sformatf("pix_act h=%0d v=%0d", h_count, v_count), pix_active, act);
    check($sformatf("pix_data h=%0d v=%0d", h_count, v_count), pix_data,
          act ? pix_exp(int'(h_count), int'(v_count)) : '0);
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_mem_en"}, bus.mem_en, 0);
    check({tag, "_gnt"}, bus.cli_gnt, 0);
    check({tag, "_rvalid"}, bus.cli_rvalid, 0);
    check({tag, "_pix_act"}, pix_active, 0);
    check({tag, "_pix_data"}, pix_data, 0);
  endtask

  // One full frame from (0,0); optionally injects the client-1 read used for the preemption case.
  task automatic frame_check(input bit with_req);
    int  act_cnt;
    bit  clr;
    act_cnt = 0;
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk_25m);
      check_pix();
      if (pix_active) act_cnt++;
      clr = 1'b0;
      if (with_req && int'(h_count) == G4_H && int'(v_count) == G4_V) begin
        check("s4_gnt", bus.cli_gnt, 2'b10);
        check("s4_mem_addr", bus.mem_addr, 40);
        clr = 1'b1;
      end else begin
        check($sformatf("idle_gnt h=%0d v=%0d", h_count, v_count), bus.cli_gnt, 0);
      end
      if (with_req && int'(h_count) == G4_H + 1 && int'(v_count) == G4_V) begin
        check("s4_rvalid", bus.cli_rvalid, 2'b10);
        check("s4_rdata", bus.cli_rdata, 40);
      end else begin
        check($sformatf("idle_rvalid h=%0d v=%0d", h_count, v_count), bus.cli_rvalid, 0);
      end
      step();
      if (clr) bus.cli_req[1] = 1'b0;
      if (with_req && h_count == 10'd10 && v_count == 10'd2) begin
        bus.cli_req[1]                 = 1'b1;
        bus.cli_we[1]                  = 1'b0;
        bus.cli_addr[ADDR_W +: ADDR_W] = 19'd40;
      end
    end
    check("frame_active_count", act_cnt, H_ACT * V_ACT);
  endtask

  initial begin
    bit at;
    for (int a = 0; a < 256; a++) ram[a] = a[DATA_W-1:0];
    rst           = 1'b1;
    h_count       = '0;
    v_count       = '0;
    bus.cli_req   = '0;
    bus.cli_we    = '0;
    bus.cli_addr  = '0;
    bus.cli_wdata = '0;
    bus.cli_req[0] = 1'b1;
    repeat (3) @(posedge clk_25m);
    @(negedge clk_25m);
    check_rst_outputs("reset");
    bus.cli_req[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("first_fetch_en", bus.mem_en, 1);
    check("first_fetch_addr", bus.mem_addr, 1);
    check("blank_pix00_act", pix_active, 0);
    step();
    @(negedge clk_25m);
    check("pix10_act", pix_active, 1);
    check("pix10_data", pix_data, 1);

    // Client 0 write to address 5 held through the scan-out slots of line 0.
    goto(10, 0);
    bus.cli_req[0]            = 1'b1;
    bus.cli_we[0]             = 1'b1;
    bus.cli_addr[0 +: ADDR_W] = 19'd5;
    bus.cli_wdata[0 +: DATA_W] = 12'hABC;
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk_25m);
      at = (int'(h_count) == S2_H) && (int'(v_count) == S2_V);
      check($sformatf("s2_gnt h=%0d v=%0d", h_count, v_count), bus.cli_gnt, at ? 2'b01 : 2'b00);
      if (at) begin
        check("s2_mem_we", bus.mem_we, 1);
        check("s2_mem_addr", bus.mem_addr, 5);
        check("s2_mem_wdata", bus.mem_wdata, 12'hABC);
        step();
        break;
      end
      step();
    end
    bus.cli_req[0] = 1'b0;
    wrote = 1'b1;
    @(negedge clk_25m);
    check("s2_no_rvalid", bus.cli_rvalid, 0);

    // Full frame after the write, with the active-line client-1 read.
    goto(0, 0);
    frame_check(1'b1);

    // Both clients reading continuously in vertical blanking.
    goto(0, V_ACT);
    bus.cli_req                    = 2'b11;
    bus.cli_we                     = 2'b00;
    bus.cli_addr[0 +: ADDR_W]      = 19'd20;
    bus.cli_addr[ADDR_W +: ADDR_W] = 19'd30;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_25m);
      check($sformatf("s3_gnt %0d", i), bus.cli_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("s3_addr %0d", i), bus.mem_addr, (i % 2 == 0) ? 20 : 30);
      check($sformatf("s3_we %0d", i), bus.mem_we, 0);
      if (i == 0) begin
        check("s3_rvalid 0", bus.cli_rvalid, 0);
      end else begin
        check($sformatf("s3_rvalid %0d", i), bus.cli_rvalid, (i % 2 == 1) ? 2'b01 : 2'b10);
        check($sformatf("s3_rdata %0d", i), bus.cli_rdata, (i % 2 == 1) ? 20 : 30);
      end
      step();
    end
    bus.cli_req = 2'b00;
    @(negedge clk_25m);
    check("s3_last_rvalid", bus.cli_rvalid, 2'b10);
    check("s3_last_rdata", bus.cli_rdata, 30);

    // Mid-frame reset, then a clean frame after resynchronisation.
    goto(5, 3);
    rst = 1'b1;
    bus.cli_req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_25m);
      check_rst_outputs($sformatf("midrst%0d", i));
      step();
    end
    bus.cli_req[0] = 1'b0;
    rst = 1'b0;
    goto(0, 0);
    frame_check(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
